bsg_chip_link_loopback_ctrl: RTL and testbench
==============================================

// Module: bsg_chip_link_loopback_ctrl
//
// PURPOSE
//  Runtime-switchable loopback between chip IO links and core ready/valid links, num_links_p channels.
//  Replaces the hardwired links_i=links_o loopback. Each channel is CORE (pass-through) or LOOP (io in -> io out).
//  Mode changes take effect only at packet boundaries, so no flit is torn or dropped.
//  Sits between bsg_chip_io_links_ct_fifo links_i/links_o and the core, in the hb core clock domain.
//
// PARAMETERS
//  num_links_p    16  number of independent channels
//  link_width_p   32  flit data width (bsg_ready_and_link_sif data field)
//  len_width_p     4  header flit bits [len_width_p-1:0] = number of body flits after the header
//  count_width_p  32  per-channel saturating loopback flit counter width
//
// PORTS
//  clk_i           in   1                    core clock
//  reset_i         in   1                    synchronous, active-high reset
//  loopback_en_i   in   num_links_p          requested mode per channel: 1=LOOP, 0=CORE
//  clear_i         in   num_links_p          clear loopback flit counter of channel
//  mode_r_o        out  num_links_p          current committed mode per channel
//  pending_o       out  num_links_p          mode change requested but not yet committed
//  loop_count_o    out  num_links_p x count_width_p  flits returned in LOOP mode, saturating
//  io_links_i      in   num_links_p x sif    from bsg_chip_io_links_ct_fifo links_o
//  io_links_o      out  num_links_p x sif    to bsg_chip_io_links_ct_fifo links_i
//  core_links_i    in   num_links_p x sif    from core
//  core_links_o    out  num_links_p x sif    to core
//  (sif = bsg_ready_and_link_sif_s of link_width_p: v, data, ready_and_rev)
//
// BEHAVIOUR
//  - Reset: mode_r_o=0 (CORE), pending_o=0, counters 0, loop FIFO emptied, in/out packet counters 0.
//    While reset_i=1, every v and ready_and_rev output is 0.
//  - CORE: io_links_o.{v,data} = core_links_i, core_links_o.{v,data} = io_links_i. Ready passes back both ways.
//    Combinational, 0-cycle latency.
//  - LOOP: io inbound flits go into a 2-entry FIFO. io ready_and_rev_o = FIFO not full.
//    FIFO head drives io_links_o.v/data and is dequeued on io ready. Latency is 1 cycle, full throughput.
//    core_links_o.v=0 and core_links_o.ready_and_rev=0 (core outbound stalled, not dropped).
//  - Boundary tracking, per direction:
//    in_cnt counts accepted io->chip flits. out_cnt counts flits sent on io_links_o (source core or FIFO).
//    On accept with cnt==0 (header): cnt <= hdr[len_width_p-1:0]. Otherwise cnt <= cnt-1.
//    A header with len=0 leaves cnt at 0.
//  - Channel FSM: {CORE, LOOP} x pending flag.
//    pending = (loopback_en_i != mode_r). If loopback_en_i reverts before commit, pending clears and no switch occurs.
//    While pending:
//      in_cnt==0  -> io ready_and_rev_o forced 0 (new header blocked).
//      out_cnt==0 -> io_links_o.v forced 0; core ready / FIFO deq blocked.
//      Body flits of open packets continue to flow.
//    Commit when pending && in_cnt==0 && out_cnt==0 && FIFO empty.
//    mode_r flips on the next clk edge. The new mode governs that next cycle; pending_o drops the same edge.
//  - loop_count: +1 per FIFO dequeue, saturates at all-ones. clear_i has priority over a same-cycle increment (result 0).
//  - Reset mid-packet: FIFO contents and partial packets are discarded; all channels return to CORE.
//  - Channels are fully independent; no cross-channel arbitration.
//
// STRUCTURE
//  - bsg_chip_pkg gains: typedef enum logic {e_link_mode_core, e_link_mode_loop} bsg_chip_link_mode_e;
//    and the loopback defaults (len_width_gp, loop_count_width_gp).
//  - Sub-module bsg_chip_link_loopback_ctrl_chan: one channel (FSM, two counters, bsg_two_fifo, saturating counter).
//    The top is a generate loop over num_links_p plus struct packing.
//
// TESTING
//  1 Reset, CORE: core sends 3-flit packet (hdr len=2) -> appears on io_links_o same cycle; mode_r_o=0, loop_count=0.
//  2 LOOP: set loopback_en_i[0]=1 idle -> mode_r_o[0]=1 after 1 cycle. Inject hdr len=3 + 3 body ->
//    4 flits on io_links_o, each 1 cycle after accept; loop_count_o[0]=4.
//  3 Mid-packet switch: in LOOP, after header (len=5) + 2 body, request CORE -> pending_o=1; remaining 3 body looped;
//    next header stalled (ready=0) until commit; then passes to core_links_o.
//  4 Backpressure: LOOP, io ready=0 for 10 cycles -> io ready_and_rev_o drops after 2 accepts; no flit lost or duplicated.
//  5 Edge cases: request then revert before boundary -> no commit, pending_o returns 0.
//    clear_i with increment -> count 0. count_width_p=4: 20 flits -> 15.
//  6 Reset mid-packet in LOOP with FIFO full -> next cycle all v/ready 0.
//    After release: CORE mode, counters 0, no stale flit emitted.

Source files
------------

// File: rtl/bsg_chip_link_loopback_ctrl_pkg.sv
// Shared types and defaults for the chip link loopback controller.
package bsg_chip_link_loopback_ctrl_pkg;

    typedef enum logic {
        e_link_mode_core = 1'b0,
        e_link_mode_loop = 1'b1
    } bsg_chip_link_mode_e;

    // Header flit length field width and loopback counter width defaults.
    localparam int unsigned len_width_gp        = 4;
    localparam int unsigned loop_count_width_gp = 32;

endpackage

// File: rtl/bsg_chip_link_loopback_ctrl_if.sv
// Ready/valid link bundles between the io-side link FIFOs, the loopback controller and the core.
interface bsg_chip_link_loopback_ctrl_if #(
    parameter int unsigned num_links_p  = 16,
    parameter int unsigned link_width_p = 32
);

    typedef struct packed {
        logic                    v;
        logic [link_width_p-1:0] data;
        logic                    ready_and_rev;
    } link_sif_s;

    link_sif_s [num_links_p-1:0] io_links_i;
    link_sif_s [num_links_p-1:0] io_links_o;
    link_sif_s [num_links_p-1:0] core_links_i;
    link_sif_s [num_links_p-1:0] core_links_o;

    // Environment side: drives the inbound bundles.
    modport master (output io_links_i, output core_links_i, input io_links_o, input core_links_o);
    // Controller side.
    modport slave  (input io_links_i, input core_links_i, output io_links_o, output core_links_o);

endinterface

// File: rtl/bsg_chip_link_loopback_ctrl_chan.sv
// One loopback channel: mode FSM with packet-boundary commit, two-entry loop FIFO,
// per-direction packet trackers and a saturating loopback flit counter.
module bsg_chip_link_loopback_ctrl_chan
    import bsg_chip_link_loopback_ctrl_pkg::*;
#(
    parameter int unsigned link_width_p  = 32,
    parameter int unsigned len_width_p   = len_width_gp,
    parameter int unsigned count_width_p = loop_count_width_gp
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     loopback_en_i,
    input  logic                     clear_i,
    output logic                     mode_r_o,
    output logic                     pending_o,
    output logic [count_width_p-1:0] loop_count_o,

    input  logic                     io_v_i,
    input  logic [link_width_p-1:0]  io_data_i,
    input  logic                     io_ready_and_i,
    output logic                     io_v_o,
    output logic [link_width_p-1:0]  io_data_o,
    output logic                     io_ready_and_o,

    input  logic                     core_v_i,
    input  logic [link_width_p-1:0]  core_data_i,
    input  logic                     core_ready_and_i,
    output logic                     core_v_o,
    output logic [link_width_p-1:0]  core_data_o,
    output logic                     core_ready_and_o
);

    bsg_chip_link_mode_e        mode_q, req_mode;
    logic [len_width_p-1:0]     in_cnt_q, out_cnt_q;
    logic [link_width_p-1:0]    fifo_mem_q [2];
    logic                       fifo_wptr_q, fifo_rptr_q;
    logic [1:0]                 fifo_cnt_q;
    logic [count_width_p-1:0]   loop_cnt_q;

    logic is_loop, pending, hold_in, hold_out, commit;
    logic fifo_empty, fifo_full, in_fire, out_fire, enq, deq;

    assign req_mode   = loopback_en_i ? e_link_mode_loop : e_link_mode_core;
    assign is_loop    = (mode_q == e_link_mode_loop);
    assign pending    = (req_mode != mode_q);
    assign fifo_empty = (fifo_cnt_q == 2'd0);
    assign fifo_full  = (fifo_cnt_q == 2'd2);
    assign hold_in    = pending & (in_cnt_q == '0);
    // Only a core source is held at a boundary; in loop mode the FIFO only ever holds
    // flits accepted before the inbound hold, and commit already waits for it to drain.
    assign hold_out   = pending & (out_cnt_q == '0) & ~is_loop;
    assign commit     = pending & (in_cnt_q == '0) & (out_cnt_q == '0) & fifo_empty;

    assign mode_r_o     = is_loop;
    assign pending_o    = pending;
    assign loop_count_o = loop_cnt_q;

    // Datapath steering for the committed mode; all handshakes silenced during reset.
    always_comb begin
        io_v_o           = 1'b0;
        io_ready_and_o   = 1'b0;
        core_v_o         = 1'b0;
        core_ready_and_o = 1'b0;
        if (!reset_i) begin
            if (is_loop) begin
                io_ready_and_o = ~fifo_full & ~hold_in;
                io_v_o         = ~fifo_empty;
            end else begin
                io_v_o           = core_v_i & ~hold_out;
                core_ready_and_o = io_ready_and_i & ~hold_out;
                core_v_o         = io_v_i & ~hold_in;
                io_ready_and_o   = core_ready_and_i & ~hold_in;
            end
        end
        io_data_o   = is_loop ? fifo_mem_q[fifo_rptr_q] : core_data_i;
        core_data_o = io_data_i;
    end

    assign in_fire  = io_v_i & io_ready_and_o;
    assign out_fire = io_v_o & io_ready_and_i;
    assign enq      = in_fire & is_loop;
    assign deq      = out_fire & is_loop;

    // Mode FSM plus inbound/outbound packet trackers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mode_q    <= e_link_mode_core;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (commit) mode_q <= req_mode;
            if (in_fire)
                in_cnt_q <= (in_cnt_q == '0) ? io_data_i[len_width_p-1:0]
                                             : in_cnt_q - len_width_p'(1);
            if (out_fire)
                out_cnt_q <= (out_cnt_q == '0) ? io_data_o[len_width_p-1:0]
                                               : out_cnt_q - len_width_p'(1);
        end
    end

    // Two-entry loop FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            if (enq) fifo_wptr_q <= ~fifo_wptr_q;
            if (deq) fifo_rptr_q <= ~fifo_rptr_q;
            fifo_cnt_q <= fifo_cnt_q + 2'(enq) - 2'(deq);
        end
    end

    // Loop FIFO storage; contents are only observable while occupancy is nonzero.
    always_ff @(posedge clk_i) begin
        if (enq) fifo_mem_q[fifo_wptr_q] <= io_data_i;
    end

    // Saturating count of looped flits; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i)
            loop_cnt_q <= '0;
        else if (deq && !(&loop_cnt_q))
            loop_cnt_q <= loop_cnt_q + count_width_p'(1);
    end

endmodule

// File: rtl/bsg_chip_link_loopback_ctrl.sv
// Runtime-switchable per-channel loopback between io links and core links.
module bsg_chip_link_loopback_ctrl
    import bsg_chip_link_loopback_ctrl_pkg::*;
#(
    parameter int unsigned num_links_p   = 16,
    parameter int unsigned link_width_p  = 32,
    parameter int unsigned len_width_p   = len_width_gp,
    parameter int unsigned count_width_p = loop_count_width_gp
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [num_links_p-1:0]                   loopback_en_i,
    input  logic [num_links_p-1:0]                   clear_i,
    output logic [num_links_p-1:0]                   mode_r_o,
    output logic [num_links_p-1:0]                   pending_o,
    output logic [num_links_p-1:0][count_width_p-1:0] loop_count_o,
    bsg_chip_link_loopback_ctrl_if.slave             links
);

    logic [num_links_p-1:0]                   io_v, io_rdy, core_v, core_rdy;
    logic [num_links_p-1:0][link_width_p-1:0] io_data, core_data;

    for (genvar i = 0; i < num_links_p; i++) begin : g_chan
        bsg_chip_link_loopback_ctrl_chan #(
            .link_width_p  (link_width_p),
            .len_width_p   (len_width_p),
            .count_width_p (count_width_p)
        ) u_chan (
            .clk_i            (clk_i),
            .reset_i          (reset_i),
            .loopback_en_i    (loopback_en_i[i]),
            .clear_i          (clear_i[i]),
            .mode_r_o         (mode_r_o[i]),
            .pending_o        (pending_o[i]),
            .loop_count_o     (loop_count_o[i]),
            .io_v_i           (links.io_links_i[i].v),
            .io_data_i        (links.io_links_i[i].data),
            .io_ready_and_i   (links.io_links_i[i].ready_and_rev),
            .io_v_o           (io_v[i]),
            .io_data_o        (io_data[i]),
            .io_ready_and_o   (io_rdy[i]),
            .core_v_i         (links.core_links_i[i].v),
            .core_data_i      (links.core_links_i[i].data),
            .core_ready_and_i (links.core_links_i[i].ready_and_rev),
            .core_v_o         (core_v[i]),
            .core_data_o      (core_data[i]),
            .core_ready_and_o (core_rdy[i])
        );
    end

    // Pack per-channel outputs back into the link structs.
    always_comb begin
        for (int unsigned i = 0; i < num_links_p; i++) begin
            links.io_links_o[i].v               = io_v[i];
            links.io_links_o[i].data            = io_data[i];
            links.io_links_o[i].ready_and_rev   = io_rdy[i];
            links.core_links_o[i].v             = core_v[i];
            links.core_links_o[i].data          = core_data[i];
            links.core_links_o[i].ready_and_rev = core_rdy[i];
        end
    end

endmodule

// File: tb/tb_bsg_chip_link_loopback_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a packet-level model.
module tb_bsg_chip_link_loopback_ctrl;

    localparam int N  = 2;
    localparam int W  = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] en, clr, mode_r, pend;
    logic [N-1:0][CW-1:0] cnt;

    int total = 0;
    int bad   = 0;

    bsg_chip_link_loopback_ctrl_if #(.num_links_p(N), .link_width_p(W)) lif ();

    bsg_chip_link_loopback_ctrl #(
        .num_links_p   (N),
        .link_width_p  (W),
        .len_width_p   (4),
        .count_width_p (CW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (rst),
        .loopback_en_i (en),
        .clear_i       (clr),
        .mode_r_o      (mode_r),
        .pending_o     (pend),
        .loop_count_o  (cnt),
        .links         (lif)
    );

    always #5 clk = ~clk;

    // Model state: committed mode, flits left in the open packet per direction,
    // loop queue contents and the looped-flit tally.
    bit          m_mode [N];
    int          m_in   [N];
    int          m_out  [N];
    int          m_cnt  [N];
    int          m_qn   [N];
    logic [31:0] m_q    [N][2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_io(input int c, input logic v, input logic [31:0] d, input logic rdy);
        lif.io_links_i[c].v = v;
        lif.io_links_i[c].data = d;
        lif.io_links_i[c].ready_and_rev = rdy;
    endtask

    task automatic set_core(input int c, input logic v, input logic [31:0] d, input logic rdy);
        lif.core_links_i[c].v = v;
        lif.core_links_i[c].data = d;
        lif.core_links_i[c].ready_and_rev = rdy;
    endtask

    // One clock: compare every output with the model, then advance the model.
    task automatic tick();
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            bit pend_e, blk_in, blk_out, e_iov, e_iordy, e_cv, e_crdy, acc, snd, commit;
            logic [31:0] e_iod, din;
            if (rst) begin
                check_eq("rst_io_v",    lif.io_links_o[c].v, 0);
                check_eq("rst_io_rdy",  lif.io_links_o[c].ready_and_rev, 0);
                check_eq("rst_core_v",  lif.core_links_o[c].v, 0);
                check_eq("rst_core_rdy", lif.core_links_o[c].ready_and_rev, 0);
                m_mode[c] = 0; m_in[c] = 0; m_out[c] = 0; m_qn[c] = 0; m_cnt[c] = 0;
                continue;
            end
            din     = lif.io_links_i[c].data;
            pend_e  = (en[c] != m_mode[c]);
            blk_in  = pend_e && m_in[c] == 0;
            blk_out = pend_e && m_out[c] == 0 && !m_mode[c];
            if (m_mode[c]) begin
                e_iordy = (m_qn[c] < 2) && !blk_in;
                e_iov   = (m_qn[c] > 0);
                e_iod   = m_q[c][0];
                e_cv    = 0;
                e_crdy  = 0;
            end else begin
                e_iov   = lif.core_links_i[c].v && !blk_out;
                e_iod   = lif.core_links_i[c].data;
                e_crdy  = lif.io_links_i[c].ready_and_rev && !blk_out;
                e_cv    = lif.io_links_i[c].v && !blk_in;
                e_iordy = lif.core_links_i[c].ready_and_rev && !blk_in;
            end
            check_eq("mode",     mode_r[c], m_mode[c]);
            check_eq("pending",  pend[c], pend_e);
            check_eq("count",    cnt[c], 64'(m_cnt[c]));
            check_eq("io_v",     lif.io_links_o[c].v, e_iov);
            check_eq("io_rdy",   lif.io_links_o[c].ready_and_rev, e_iordy);
            check_eq("core_v",   lif.core_links_o[c].v, e_cv);
            check_eq("core_rdy", lif.core_links_o[c].ready_and_rev, e_crdy);
            if (e_iov) check_eq("io_data", lif.io_links_o[c].data, e_iod);
            if (e_cv)  check_eq("core_data", lif.core_links_o[c].data, din);

            acc    = lif.io_links_i[c].v && e_iordy;
            snd    = e_iov && lif.io_links_i[c].ready_and_rev;
            commit = pend_e && m_in[c] == 0 && m_out[c] == 0 && m_qn[c] == 0;
            if (acc) m_in[c]  = (m_in[c] == 0)  ? int'(din[3:0])   : m_in[c] - 1;
            if (snd) m_out[c] = (m_out[c] == 0) ? int'(e_iod[3:0]) : m_out[c] - 1;
            if (m_mode[c]) begin
                if (snd) begin
                    m_q[c][0] = m_q[c][1];
                    m_qn[c]--;
                    if (m_cnt[c] < (1 << CW) - 1) m_cnt[c]++;
                end
                if (acc) begin
                    m_q[c][m_qn[c]] = din;
                    m_qn[c]++;
                end
            end
            if (clr[c]) m_cnt[c] = 0;
            if (commit) m_mode[c] = en[c];
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] flits [5];
        logic [31:0] got [$];
        int idx, stalled_acc;
        bit acc, snd;

        rst = 1; en = '0; clr = '0;
        for (int c = 0; c < N; c++) begin
            set_io(c, 0, '0, 1);
            set_core(c, 0, '0, 1);
        end
        tick(); tick();
        rst = 0;
        tick();

        // 1: CORE pass-through, same-cycle
        check_eq("t1_mode", mode_r[0], 0);
        check_eq("t1_count", cnt[0], 0);
        set_core(0, 1, 32'hA000_0002, 1); #1;
        check_eq("t1_hdr_v", lif.io_links_o[0].v, 1);
        check_eq("t1_hdr_d", lif.io_links_o[0].data, 32'hA000_0002);
        tick();
        set_core(0, 1, 32'hB000_0001, 1); #1;
        check_eq("t1_b1_d", lif.io_links_o[0].data, 32'hB000_0001);
        tick();
        set_core(0, 1, 32'hB000_0002, 1); tick();
        set_core(0, 0, '0, 1);

        // 2: switch idle channel to LOOP, then loop a 4-flit packet
        en[0] = 1;
        tick();
        check_eq("t2_mode", mode_r[0], 1);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] f;
            f = (k == 0) ? 32'hC000_0003 : 32'hD000_0000 + k;
            set_io(0, 1, f, 1);
            tick();
            check_eq("t2_lat_v", lif.io_links_o[0].v, 1);
            check_eq("t2_lat_d", lif.io_links_o[0].data, f);
        end
        set_io(0, 0, '0, 1);
        tick(); tick();
        check_eq("t2_count", cnt[0], 4);

        // 3: mid-packet switch back to CORE
        set_io(0, 1, 32'hE000_0005, 1); tick();
        set_io(0, 1, 32'hE000_0011, 1); tick();
        set_io(0, 1, 32'hE000_0012, 1); tick();
        en[0] = 0; #1;
        check_eq("t3_pend", pend[0], 1);
        for (int k = 3; k <= 5; k++) begin
            set_io(0, 1, 32'hE000_0010 + k, 1);
            tick();
        end
        set_io(0, 1, 32'hF000_0001, 1); #1;
        check_eq("t3_hold", lif.io_links_o[0].ready_and_rev, 0);
        tick();
        check_eq("t3_hold2", lif.io_links_o[0].ready_and_rev, 0);
        check_eq("t3_pend2", pend[0], 1);
        tick();
        check_eq("t3_mode", mode_r[0], 0);
        check_eq("t3_pend_clr", pend[0], 0);
        check_eq("t3_core_v", lif.core_links_o[0].v, 1);
        check_eq("t3_core_d", lif.core_links_o[0].data, 32'hF000_0001);
        tick();
        set_io(0, 1, 32'hF000_0010, 1); tick();
        set_io(0, 0, '0, 1);

        // 4: backpressure on channel 1 in LOOP
        en[1] = 1;
        tick();
        flits[0] = 32'h1000_0004;
        for (int k = 1; k < 5; k++) flits[k] = 32'h1100_0000 + k;
        idx = 0; stalled_acc = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (idx < 5) set_io(1, 1, flits[idx], cyc >= 10);
            else         set_io(1, 0, '0, cyc >= 10);
            #1;
            acc = lif.io_links_i[1].v && lif.io_links_o[1].ready_and_rev;
            snd = lif.io_links_o[1].v && lif.io_links_i[1].ready_and_rev;
            if (snd) got.push_back(lif.io_links_o[1].data);
            if (acc && cyc < 10) stalled_acc++;
            tick();
            if (acc) idx++;
        end
        check_eq("t4_stall_acc", 64'(stalled_acc), 2);
        check_eq("t4_recv_n", 64'(got.size()), 5);
        for (int k = 0; k < 5 && k < got.size(); k++) check_eq("t4_order", got[k], flits[k]);

        // 5a: request then revert mid-packet, no commit
        set_io(1, 1, 32'h2000_0003, 1); tick();
        set_io(1, 0, '0, 1);
        en[1] = 0; #1;
        check_eq("t5_pend", pend[1], 1);
        tick();
        en[1] = 1; #1;
        check_eq("t5_revert", pend[1], 0);
        for (int k = 1; k <= 3; k++) begin
            set_io(1, 1, 32'h2100_0000 + (k << 4), 1);
            tick();
        end
        set_io(1, 0, '0, 1);
        tick(); tick();
        check_eq("t5_nocommit", mode_r[1], 1);

        // 5b: clear coincident with a dequeue
        set_io(1, 1, 32'h3000_0000, 1); tick();
        set_io(1, 0, '0, 1);
        clr[1] = 1; tick();
        clr[1] = 0; #1;
        check_eq("t5_clr", cnt[1], 0);

        // 5c: saturation on channel 0 with 20 single-flit packets
        en[0] = 1; clr[0] = 1; tick();
        clr[0] = 0;
        for (int k = 0; k < 20; k++) begin
            set_io(0, 1, 32'h4000_0000 + (k << 4), 1);
            tick();
        end
        set_io(0, 0, '0, 1);
        tick(); tick();
        check_eq("t5_sat", cnt[0], 15);

        // 6: reset with a full loop FIFO
        set_io(0, 1, 32'h5000_0005, 0); tick();
        set_io(0, 1, 32'h5000_0010, 0); tick();
        set_io(0, 1, 32'h5000_0020, 0); tick();
        rst = 1; #1;
        for (int c = 0; c < N; c++) begin
            check_eq("t6_io_v",    lif.io_links_o[c].v, 0);
            check_eq("t6_io_rdy",  lif.io_links_o[c].ready_and_rev, 0);
            check_eq("t6_core_v",  lif.core_links_o[c].v, 0);
            check_eq("t6_core_rdy", lif.core_links_o[c].ready_and_rev, 0);
        end
        tick();
        rst = 0; en = '0;
        for (int c = 0; c < N; c++) set_io(c, 0, '0, 1);
        tick();
        check_eq("t6_mode", mode_r, 0);
        check_eq("t6_count", cnt, 0);
        for (int k = 0; k < 3; k++) begin
            check_eq("t6_no_stale", lif.io_links_o[0].v, 0);
            tick();
        end

        // Randomized traffic, mode flips, clears and occasional reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
                clr[c] = ($urandom_range(0, 49) == 0);
                set_io(c, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFF3,
                       $urandom_range(0, 3) != 0);
                set_core(c, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFF3,
                         $urandom_range(0, 3) != 0);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
